// File: rtl/dcm_fx_reconfig_ctrl.sv
// Sequences a run-time CLKFX M/D change on an X_DCM_ADV through its DRP:
// reset hold, DRP write, reset release, wait for LOCKED, report DONE or ERR.
// Build option DCM_FX_READBACK_EN adds a DRP read-back check of the written word.
// The DCM DO pin is named drp_do because "do" is a reserved word.
module dcm_fx_reconfig_ctrl #(
  parameter logic [6:0]  FX_DRP_ADDR  = 7'h50,
  parameter int unsigned RST_CYCLES   = 3,
  parameter int unsigned DRDY_TIMEOUT = 64,
  parameter int unsigned LOCK_TIMEOUT = 65535
) (
  input  logic        dclk,
  input  logic        rst,
  input  logic        req,
  input  logic [5:0]  req_m,
  input  logic [5:0]  req_d,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic        dcm_rst,
  output logic [6:0]  daddr,
  output logic        den,
  output logic        dwe,
  output logic [15:0] di,
  input  logic [15:0] drp_do,
  input  logic        drdy,
  input  logic        locked
);

  localparam int unsigned MAX_A   = (RST_CYCLES > DRDY_TIMEOUT) ? RST_CYCLES : DRDY_TIMEOUT;
  localparam int unsigned CNT_MAX = (MAX_A > LOCK_TIMEOUT) ? MAX_A : LOCK_TIMEOUT;
  localparam int          CW      = $clog2(CNT_MAX + 1);

  localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] DRDY_LAST = CW'(DRDY_TIMEOUT - 1);
  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_CHECK,
    S_RST_HOLD,
    S_DRP_WR,
    S_WAIT_WR,
`ifdef DCM_FX_READBACK_EN
    S_DRP_RD,
    S_WAIT_RD,
`endif
    S_RELEASE,
    S_WAIT_LOCK,
    S_FINISH,
    S_FAIL
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [5:0]    m_q;
  logic [5:0]    d_q;
  logic          md_ok;

  // Range check runs on the latched request so it never sees the raw pins.
  assign md_ok = (m_q >= 6'd2) && (m_q <= 6'd32) && (d_q >= 6'd1) && (d_q <= 6'd32);

`ifndef DCM_FX_READBACK_EN
  logic unused_do;
  assign unused_do = ^drp_do;
`endif

  always_ff @(posedge dclk) begin
    // NOTE: reset is synchronous and active-high, so it lives inside the clocked
    // block; every state element uses <= so all of them update from the same edge.
    if (rst) begin
      state    <= S_IDLE;
      cnt      <= '0;
      m_q      <= '0;
      d_q      <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      err_code <= 2'b00;
      dcm_rst  <= 1'b0;
      daddr    <= '0;
      den      <= 1'b0;
      dwe      <= 1'b0;
      di       <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (req) begin
            m_q      <= req_m;
            d_q      <= req_d;
            busy     <= 1'b1;
            err_code <= 2'b00;
            state    <= S_CHECK;
          end
        end
        S_CHECK: begin
          if (md_ok) begin
            dcm_rst <= 1'b1;
            cnt     <= '0;
            state   <= S_RST_HOLD;
          end else begin
            err      <= 1'b1;
            err_code <= 2'b01;
            state    <= S_FAIL;
          end
        end
        S_RST_HOLD: begin
          if (cnt == RST_LAST) begin
            den   <= 1'b1;
            dwe   <= 1'b1;
            daddr <= FX_DRP_ADDR;
            di    <= {2'b00, m_q - 6'd1, 2'b00, d_q - 6'd1};
            state <= S_DRP_WR;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DRP_WR: begin
          den   <= 1'b0;
          dwe   <= 1'b0;
          cnt   <= '0;
          state <= S_WAIT_WR;
        end
        S_WAIT_WR: begin
          // DRDY on the last allowed cycle still wins over the timeout.
          if (drdy) begin
`ifdef DCM_FX_READBACK_EN
            den   <= 1'b1;
            state <= S_DRP_RD;
`else
            dcm_rst <= 1'b0;
            state   <= S_RELEASE;
`endif
          end else if (cnt == DRDY_LAST) begin
            err      <= 1'b1;
            err_code <= 2'b10;
            dcm_rst  <= 1'b0;
            state    <= S_FAIL;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef DCM_FX_READBACK_EN
        S_DRP_RD: begin
          den   <= 1'b0;
          cnt   <= '0;
          state <= S_WAIT_RD;
        end
        S_WAIT_RD: begin
          if (drdy) begin
            dcm_rst <= 1'b0;
            if (drp_do == di) begin
              state <= S_RELEASE;
            end else begin
              err      <= 1'b1;
              err_code <= 2'b01;
              state    <= S_FAIL;
            end
          end else if (cnt == DRDY_LAST) begin
            err      <= 1'b1;
            err_code <= 2'b10;
            dcm_rst  <= 1'b0;
            state    <= S_FAIL;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        S_RELEASE: begin
          cnt   <= '0;
          state <= S_WAIT_LOCK;
        end
        S_WAIT_LOCK: begin
          if (locked) begin
            done  <= 1'b1;
            state <= S_FINISH;
          end else if (cnt == LOCK_LAST) begin
            err      <= 1'b1;
            err_code <= 2'b11;
            state    <= S_FAIL;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_FINISH, S_FAIL: begin
          busy  <= 1'b0;
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dcm_fx_reconfig_ctrl.sv
// Self-checking bench for dcm_fx_reconfig_ctrl: directed vector table, random
// vectors against a timing model, and hand sequences for reset/REQ corner cases.
module tb_dcm_fx_reconfig_ctrl;

  localparam int R  = 3;
  localparam int DT = 64;
  localparam int LT = 100;
`ifdef DCM_FX_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  typedef struct {
    int          m;
    int          d;
    int          dd;    // DRDY delay after the DEN cycle, 0 = never
    int          ld;    // LOCKED delay counted from the first released cycle, 0 = never
    logic [15:0] flip;  // bits inverted on read data
    bit          ok;
    logic [1:0]  code;
    int          lat;   // edges from the accepting edge to the DONE/ERR edge
    logic [15:0] di;
    int          nwr;
    int          nrd;
  } vec_t;

  logic        dclk = 1'b0;
  logic        rst, req;
  logic [5:0]  req_m, req_d;
  logic        busy, done, err;
  logic [1:0]  err_code;
  logic        dcm_rst;
  logic [6:0]  daddr;
  logic        den, dwe;
  logic [15:0] di;
  logic [15:0] drp_do;
  logic        drdy, locked;

  int          drdy_dly, lock_dly;
  logic [15:0] flip;
  int          n_tests = 0;
  int          n_fail  = 0;

  always #5 dclk = ~dclk;

  dcm_fx_reconfig_ctrl #(
    .FX_DRP_ADDR (7'h50),
    .RST_CYCLES  (R),
    .DRDY_TIMEOUT(DT),
    .LOCK_TIMEOUT(LT)
  ) dut (
    .dclk(dclk), .rst(rst), .req(req), .req_m(req_m), .req_d(req_d),
    .busy(busy), .done(done), .err(err), .err_code(err_code),
    .dcm_rst(dcm_rst), .daddr(daddr), .den(den), .dwe(dwe), .di(di),
    .drp_do(drp_do), .drdy(drdy), .locked(locked)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Behavioural DCM: DRP register, DRDY after a programmable delay, LOCKED after release.
  initial begin : dcm_model
    int pend, lcnt;
    bit armed;
    logic [15:0] drp_reg, rd_val;
    pend = 0; lcnt = 0; armed = 0; drp_reg = '0; rd_val = '0;
    drdy = 1'b0; locked = 1'b0; drp_do = '0;
    forever begin
      @(negedge dclk);
      drdy = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          drdy   = 1'b1;
          drp_do = rd_val;
        end
      end
      if (den) begin
        if (dwe) drp_reg = di;
        else     rd_val  = drp_reg ^ flip;
        if (drdy_dly > 0) pend = drdy_dly;
      end
      if (dcm_rst) begin
        armed = 1; lcnt = 0; locked = 1'b0;
      end else if (armed) begin
        lcnt++;
        if (lock_dly > 0 && lcnt == lock_dly) begin
          locked = 1'b1;
          armed  = 0;
        end
      end
    end
  end

  // Expected outcome from the sequencing rules, as edge arithmetic.
  function automatic vec_t model(input vec_t v);
    vec_t e;
    int   w, rel;
    e      = v;
    e.ok   = 1'b0;
    e.code = 2'b00;
    e.nwr  = 0;
    e.nrd  = 0;
    e.di   = {8'(v.m - 1), 8'(v.d - 1)};
    if (v.m < 2 || v.m > 32 || v.d < 1 || v.d > 32) begin
      e.code = 2'b01; e.lat = 1; e.di = '0;
      return e;
    end
    e.nwr = 1;
    if (v.dd < 1 || v.dd > DT) begin
      e.code = 2'b10; e.lat = 2 + R + DT;
      return e;
    end
    w   = 2 + R + v.dd;
    rel = w;
    if (RB) begin
      e.nrd = 1;
      rel   = w + 1 + v.dd;
      if (v.flip != 0) begin
        e.code = 2'b01; e.lat = rel;
        return e;
      end
    end
    if (v.ld < 1 || v.ld > LT + 1) begin
      e.code = 2'b11; e.lat = rel + 1 + LT;
      return e;
    end
    e.ok  = 1'b1;
    e.lat = (v.ld > 2) ? rel + v.ld : rel + 2;
    return e;
  endfunction

  task automatic run_vec(input string tag, input vec_t v);
    int nwr, nrd, rst_hi, lat;
    bit seen, ok, busy_ok, rst_at;
    logic [15:0] wdi;
    logic [6:0]  wad;
    logic [1:0]  code;
    nwr = 0; nrd = 0; rst_hi = 0; lat = -1;
    seen = 0; ok = 0; busy_ok = 1; rst_at = 0; wdi = '0; wad = '0; code = '0;
    drdy_dly = v.dd; lock_dly = v.ld; flip = v.flip;
    @(negedge dclk);
    req = 1'b1; req_m = 6'(v.m); req_d = 6'(v.d);
    @(negedge dclk);
    req = 1'b0; req_m = 6'($urandom); req_d = 6'($urandom);
    check({tag, ".code_cleared"}, err_code, 2'b00);
    for (int n = 0; n < 400 && !seen; n++) begin
      if (den) begin
        if (dwe) begin nwr++; wdi = di; wad = daddr; end
        else nrd++;
      end
      if (dcm_rst && nwr == 0 && !den) rst_hi++;
      if (!busy) busy_ok = 0;
      if (done || err) begin
        seen = 1; lat = n; ok = done; code = err_code; rst_at = dcm_rst;
        if (done && err) busy_ok = 0;
      end else begin
        @(negedge dclk);
      end
    end
    check({tag, ".pulse_seen"}, seen, 1'b1);
    check({tag, ".outcome"}, ok, v.ok);
    check({tag, ".err_code"}, code, v.code);
    check({tag, ".latency"}, lat, v.lat);
    check({tag, ".den_wr"}, nwr, v.nwr);
    check({tag, ".den_rd"}, nrd, v.nrd);
    check({tag, ".busy"}, busy_ok, 1'b1);
    check({tag, ".rst_at_pulse"}, rst_at, 1'b0);
    if (v.nwr > 0) begin
      check({tag, ".di"}, wdi, v.di);
      check({tag, ".daddr"}, wad, 7'h50);
      check({tag, ".rst_hold"}, rst_hi, R);
    end else begin
      check({tag, ".rst_hold"}, rst_hi, 0);
    end
    @(negedge dclk);
    check({tag, ".idle_after"}, {busy, done, err, den}, 4'b0000);
    check({tag, ".code_held"}, err_code, v.code);
    if (!seen) begin
      rst = 1'b1;
      @(negedge dclk);
      rst = 1'b0;
    end
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    vec_t dir[14];
    vec_t v;
    int   nden, pulses, act;
    bit   seen;

    dir[0]  = '{5, 2, 1, 10, 16'h0, 1'b1, 2'd0, RB ? 18 : 16, 16'h0401, 1, RB};
    dir[1]  = '{1, 4, 1, 10, 16'h0, 1'b0, 2'd1, 1, 16'h0, 0, 0};
    dir[2]  = '{33, 1, 1, 10, 16'h0, 1'b0, 2'd1, 1, 16'h0, 0, 0};
    dir[3]  = '{2, 0, 1, 10, 16'h0, 1'b0, 2'd1, 1, 16'h0, 0, 0};
    dir[4]  = '{2, 33, 1, 10, 16'h0, 1'b0, 2'd1, 1, 16'h0, 0, 0};
    dir[5]  = '{2, 1, 1, 1, 16'h0, 1'b1, 2'd0, RB ? 10 : 8, 16'h0100, 1, RB};
    dir[6]  = '{32, 32, 64, 2, 16'h0, 1'b1, 2'd0, RB ? 136 : 71, 16'h1F1F, 1, RB};
    dir[7]  = '{5, 2, 0, 2, 16'h0, 1'b0, 2'd2, 69, 16'h0401, 1, 0};
    dir[8]  = '{5, 2, 65, 2, 16'h0, 1'b0, 2'd2, 69, 16'h0401, 1, 0};
    dir[9]  = '{5, 2, 1, 0, 16'h0, 1'b0, 2'd3, RB ? 109 : 107, 16'h0401, 1, RB};
    dir[10] = '{32, 32, 1, 3, 16'h0, 1'b1, 2'd0, RB ? 11 : 9, 16'h1F1F, 1, RB};
    dir[11] = '{3, 3, 1, 101, 16'h0, 1'b1, 2'd0, RB ? 109 : 107, 16'h0202, 1, RB};
    dir[12] = '{3, 3, 1, 102, 16'h0, 1'b0, 2'd3, RB ? 109 : 107, 16'h0202, 1, RB};
    dir[13] = '{5, 2, 1, 10, 16'h0003, !RB, RB ? 2'd1 : 2'd0, RB ? 8 : 16, 16'h0401, 1, RB};

    rst = 1'b1; req = 1'b0; req_m = '0; req_d = '0;
    drdy_dly = 1; lock_dly = 1; flip = '0;
    repeat (3) @(negedge dclk);
    check("reset.outputs", {busy, done, err, err_code, dcm_rst, daddr, den, dwe, di}, '0);
    rst = 1'b0;

    for (int i = 0; i < 14; i++) run_vec($sformatf("dir%0d", i), dir[i]);

    for (int i = 0; i < 24; i++) begin
      v.m    = $urandom_range(0, 40);
      v.d    = $urandom_range(0, 40);
      v.dd   = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6);
      v.ld   = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 12);
      v.flip = ($urandom_range(0, 3) == 0) ? 16'h0010 : 16'h0000;
      run_vec($sformatf("rnd%0d", i), model(v));
    end

    // Reset during WAIT_LOCK with REQ pulses injected while busy.
    drdy_dly = 1; lock_dly = 0; flip = '0; nden = 0; pulses = 0;
    @(negedge dclk);
    req = 1'b1; req_m = 6'd5; req_d = 6'd2;
    @(negedge dclk);
    for (int n = 0; n < 14; n++) begin
      if (den) nden++;
      if (done || err) pulses++;
      req   = (n % 4 == 1);
      req_m = 6'd9; req_d = 6'd9;
      @(negedge dclk);
    end
    req = 1'b0;
    check("rst_mid.busy_before", {busy, dcm_rst}, 2'b10);
    rst = 1'b1;
    @(negedge dclk);
    check("rst_mid.outputs", {busy, done, err, err_code, dcm_rst, daddr, den, dwe, di}, '0);
    rst = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(negedge dclk);
      if (den) nden++;
      if (done || err || busy) pulses++;
    end
    check("rst_mid.den_total", nden, RB ? 2 : 1);
    check("rst_mid.no_pulse", pulses, 0);

    // REQ presented on the DONE cycle is not accepted.
    drdy_dly = 1; lock_dly = 1; seen = 0; act = 0;
    @(negedge dclk);
    req = 1'b1; req_m = 6'd4; req_d = 6'd4;
    @(negedge dclk);
    req = 1'b0;
    for (int n = 0; n < 60 && !seen; n++) begin
      if (done) begin
        seen = 1;
        req  = 1'b1;
      end
      @(negedge dclk);
    end
    req = 1'b0;
    check("req_on_done.seen", seen, 1'b1);
    for (int n = 0; n < 12; n++) begin
      if (busy || den || dcm_rst) act++;
      @(negedge dclk);
    end
    check("req_on_done.idle", act, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/dcm_fx_reconfig_ctrl.md
Name: dcm_fx_reconfig_ctrl

Overview:
- Sequences a run-time change of the DCM's CLKFX multiply/divide ratio through the DCM dynamic reconfiguration port (DRP).
- Sits between fabric control logic and one X_DCM_ADV instance. It drives the DCM's RST, DADDR, DEN, DWE and DI pins and monitors DO, DRDY and LOCKED.
- One request runs the full sequence: hold DCM in reset → DRP write → release reset → wait for LOCKED → report DONE or ERR.

Parameters:
- FX_DRP_ADDR, 7'h50, DRP address of the CLKFX M/D register.
- RST_CYCLES, 3, number of DCLK cycles DCM_RST is held before the DRP write (minimum 1).
- DRDY_TIMEOUT, 64, maximum DCLK cycles to wait for DRDY after a DEN pulse.
- LOCK_TIMEOUT, 65535, maximum DCLK cycles to wait for LOCKED after DCM_RST is released.

Ports:
- DCLK  in  1  single clock for the controller and the DRP.
- RST  in  1  synchronous, active-high reset.
- REQ  in  1  start request; sampled only in IDLE.
- REQ_M  in  6  requested CLKFX_MULTIPLY; legal range 2..32.
- REQ_D  in  6  requested CLKFX_DIVIDE; legal range 1..32.
- BUSY  out  1  high from the cycle after an accepted REQ until the DONE/ERR cycle, inclusive.
- DONE  out  1  one-cycle pulse on successful completion.
- ERR  out  1  one-cycle pulse on failure.
- ERR_CODE  out  2  01 = illegal M/D, 10 = DRDY timeout, 11 = lock timeout; valid while ERR is high and held until the next accepted REQ.
- DCM_RST  out  1  drives DCM RST.
- DADDR  out  7  drives DCM DADDR.
- DEN  out  1  drives DCM DEN.
- DWE  out  1  drives DCM DWE.
- DI  out  16  drives DCM DI.
- DO  in  16  DCM DO.
- DRDY  in  1  DCM DRDY.
- LOCKED  in  1  DCM LOCKED.

Behaviour:
- Reset values: BUSY=0, DONE=0, ERR=0, ERR_CODE=00, DCM_RST=0, DADDR=0, DEN=0, DWE=0, DI=0. State = IDLE; all counters are cleared.
- All outputs are registered.
- IDLE:
  - On REQ=1, latch REQ_M and REQ_D.
  - If M<2, M>32, D<1 or D>32: go to FAIL with code 01. No DRP access and no DCM_RST occur.
  - Otherwise go to RST_HOLD. BUSY and DCM_RST go to 1 on the next edge.
- RST_HOLD:
  - DCM_RST stays high for exactly RST_CYCLES cycles.
  - Then go to DRP_WR.
- DRP_WR:
  - Single cycle with DEN=1, DWE=1, DADDR=FX_DRP_ADDR, DI={M-1[7:0], D-1[7:0]}.
  - Then go to WAIT_WR.
- WAIT_WR:
  - DEN=DWE=0; DADDR and DI hold their values.
  - DRDY=1 → go to RELEASE.
  - Counter reaches DRDY_TIMEOUT → FAIL with code 10.
  - DRDY arriving on the same cycle the timeout expires counts as success.
- RELEASE:
  - DCM_RST returns to 0; go to WAIT_LOCK.
- WAIT_LOCK:
  - LOCKED=1 → go to FINISH.
  - Counter reaches LOCK_TIMEOUT → FAIL with code 11.
  - LOCKED is ignored while DCM_RST=1.
- FINISH: DONE=1 for one cycle, BUSY=1 on that same cycle, then IDLE.
- FAIL: ERR=1 for one cycle, BUSY=1 on that same cycle, DCM_RST=0, then IDLE.
- REQ while BUSY=1 is ignored and not queued.
- REQ on the DONE/ERR cycle is ignored; a new request needs REQ=1 in IDLE.
- A DRDY that arrives outside WAIT_WR (or WAIT_RD) is ignored.
- RST mid-operation:
  - All outputs return to their reset values on the next edge, including DCM_RST=0.
  - No DONE or ERR pulse is produced.
  - The DCM keeps whatever DRP contents it had.
- Minimum total latency from REQ to DONE, with DRDY and LOCKED both immediate: RST_CYCLES+5 cycles.

Optional Feature:
- Macro: DCM_FX_READBACK_EN.
- With the macro defined:
  - After WAIT_WR, the controller enters DRP_RD: one cycle with DEN=1, DWE=0, same DADDR.
  - It then enters WAIT_RD with the same timeout rule as WAIT_WR (code 10).
  - On DRDY, DO is compared with the written DI.
  - Mismatch → FAIL with code 01 and DCM_RST released.
  - Match → RELEASE.
  - Minimum latency becomes RST_CYCLES+7.
- Without the macro: DRP_RD and WAIT_RD are not built, and DEN is never asserted with DWE=0.

Test Plan:
- RST_CYCLES=3; REQ with M=5, D=2; DRDY one cycle after DEN; LOCKED 10 cycles after release → DI=16'h0401, DADDR=7'h50, DCM_RST high exactly 3 cycles before DEN, one DONE pulse, ERR never asserted.
- REQ with M=1, D=4 → ERR pulse with ERR_CODE=01 two cycles after REQ; DEN and DCM_RST never asserted.
- DRDY held low, DRDY_TIMEOUT=64 → ERR with code 10 after 64 WAIT_WR cycles; DCM_RST=0 on the ERR cycle.
- LOCKED held low, LOCK_TIMEOUT=100 → ERR with code 11 after 100 cycles; then a second REQ (M=32, D=32, DI=16'h1F1F) completes with DONE.
- RST asserted during WAIT_LOCK, with REQ pulses injected while BUSY → all outputs return to reset values next cycle; no DONE or ERR; the injected REQs cause no extra DRP access.
- DCM_FX_READBACK_EN defined; DO returns 16'h0402 against a written 16'h0401 → one DEN with DWE=0 observed, then ERR with code 01.
